// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Start/done handshake; S/C/V stay registered until the next completed operation.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_shift_c;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s_bit_c;
  logic             carry_next_c;
  logic             load_c;
  logic             last_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start is only honoured when ready (IDLE or DONE)
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load_c     = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          state_next = DONE;
          last_c     = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          load_c     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Full-adder cell on the operand LSBs; sum bit enters the result at the MSB end
  always_comb begin
    s_bit_c      = opa[0] ^ opb[0] ^ carry;
    carry_next_c = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    res_shift_c  = res >> 1;
    res_shift_c[WIDTH-1] = s_bit_c;
  end

  // Datapath and registered outputs; carry at the last edge is the carry into the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else begin
      if (load_c) begin
        opa   <= A;
        opb   <= sub ? ~B : B;
        carry <= sub | CIN;
        cnt   <= '0;
        res   <= '0;
      end else if (state == RUN) begin
        opa   <= opa >> 1;
        opb   <= opb >> 1;
        carry <= carry_next_c;
        res   <= res_shift_c;
        cnt   <= cnt + CNT_W'(1);
        if (last_c) begin
          S <= res_shift_c;
          C <= carry_next_c;
          V <= carry ^ carry_next_c;
        end
      end
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule
